// File: rtl/formation_pkg.sv
// Shared types and constants for the alien formation march controller.
package formation_pkg;

  localparam int unsigned OFFSET_W = 16;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MARCH   = 3'd1,
    DESCEND = 3'd2,
    CLEARED = 3'd3,
    INVADED = 3'd4
  } march_state_t;

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/formation_extent.sv
// Combinational extents of the live formation: outermost columns, bottom row
// and live-alien count.
module formation_extent
  import formation_pkg::*;
#(
  parameter int unsigned NUM_ROWS = 3,
  parameter int unsigned NUM_COLS = 5,
  parameter int unsigned COL_W    = idx_w(NUM_COLS),
  parameter int unsigned ROW_W    = idx_w(NUM_ROWS),
  parameter int unsigned CNT_W    = $clog2(NUM_ROWS*NUM_COLS + 1)
) (
  input  logic [NUM_ROWS*NUM_COLS-1:0] alive_matrix,
  output logic [COL_W-1:0]             col_l,
  output logic [COL_W-1:0]             col_r,
  output logic [ROW_W-1:0]             row_b,
  output logic [CNT_W-1:0]             n_alive,
  output logic                         any_alive
);

  logic [NUM_COLS-1:0] col_live;
  logic [NUM_ROWS-1:0] row_live;

  always_comb begin
    col_live = '0;
    row_live = '0;
    col_l    = '0;
    col_r    = '0;
    row_b    = '0;
    n_alive  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (alive_matrix[r*NUM_COLS + c]) begin
          col_live[c] = 1'b1;
          row_live[r] = 1'b1;
        end
      end
    end
    // Scan from the far side so the last hit wins.
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (col_live[c]) col_l = COL_W'(c);
    end
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_live[c]) col_r = COL_W'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_live[r]) row_b = ROW_W'(r);
    end
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      n_alive = n_alive + CNT_W'(alive_matrix[i]);
    end
  end

  assign any_alive = |alive_matrix;

endmodule

// File: rtl/formation_march_controller.sv
// Turns frame ticks into formation march steps: sideways moves, row drops,
// and the cleared / invaded end conditions.
module formation_march_controller
  import formation_pkg::*;
#(
  parameter int NUM_ROWS         = 3,
  parameter int NUM_COLS         = 5,
  parameter int ALIEN_SPACING_X  = 64,
  parameter int ALIEN_SPACING_Y  = 32,
  parameter int START_X          = 100,
  parameter int START_Y          = 50,
  parameter int ALIEN_W          = 32,
  parameter int ALIEN_H          = 16,
  parameter int BOUND_L          = 0,
  parameter int BOUND_R          = 640,
  parameter int INVADE_Y         = 400,
  parameter int STEP_X           = 8,
  parameter int STEP_Y           = 16,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ALIEN = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic                             enable,
  input  logic                             restart,
  input  logic [NUM_ROWS*NUM_COLS-1:0]     alive_matrix,
  output logic signed [OFFSET_W-1:0]       offset_x,
  output logic [OFFSET_W-1:0]              offset_y,
  output logic                             step_pulse,
  output logic                             direction,
  output logic                             descending,
  output logic                             cleared,
  output logic                             invaded,
  output logic [2:0]                       state_o
);

  localparam int unsigned COL_W  = idx_w(NUM_COLS);
  localparam int unsigned ROW_W  = idx_w(NUM_ROWS);
  localparam int unsigned CNT_W  = $clog2(NUM_ROWS*NUM_COLS + 1);
  localparam int unsigned EDGE_W = OFFSET_W + 1;
  localparam int unsigned PER_W  = 16;

  march_state_t                state_q, state_d;
  logic [PER_W-1:0]            frame_cnt_q, frame_cnt_d;
  logic signed [OFFSET_W-1:0]  offset_x_q, offset_x_d;
  logic [OFFSET_W-1:0]         offset_y_q, offset_y_d;
  logic                        direction_q, direction_d;
  logic                        step_pulse_q, step_pulse_d;
  logic                        descending_q, descending_d;
  logic                        cleared_q, cleared_d;
  logic                        invaded_q, invaded_d;

  logic [COL_W-1:0]  col_l_c;
  logic [COL_W-1:0]  col_r_c;
  logic [ROW_W-1:0]  row_b_c;
  logic [CNT_W-1:0]  n_alive_c;
  logic              any_alive_c;

  formation_extent #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W),
    .CNT_W    (CNT_W)
  ) u_extent (
    .alive_matrix (alive_matrix),
    .col_l        (col_l_c),
    .col_r        (col_r_c),
    .row_b        (row_b_c),
    .n_alive      (n_alive_c),
    .any_alive    (any_alive_c)
  );

  logic [PER_W-1:0]  period_c;
  logic [EDGE_W-1:0] ext_x_c;
  logic [EDGE_W-1:0] edge_r_c;
  logic [EDGE_W-1:0] edge_l_c;
  logic [EDGE_W-1:0] bottom_next_c;
  logic              blocked_r_c;
  logic              blocked_l_c;
  logic              blocked_c;
  logic              step_due_c;
  logic              invade_c;
  logic              active_c;

  // Period only meaningful with at least one alien; clear overrides otherwise.
  assign period_c   = PER_W'(MIN_PERIOD)
                    + PER_W'((int'(n_alive_c) - 1) * PERIOD_PER_ALIEN);
  assign step_due_c = (frame_cnt_q + PER_W'(1)) >= period_c;

  // 17-bit signed edge positions so offsets near the bounds never wrap.
  assign ext_x_c  = {offset_x_q[OFFSET_W-1], offset_x_q};
  assign edge_r_c = EDGE_W'(START_X + ALIEN_W)
                  + EDGE_W'(int'(col_r_c) * ALIEN_SPACING_X) + ext_x_c;
  assign edge_l_c = EDGE_W'(START_X)
                  + EDGE_W'(int'(col_l_c) * ALIEN_SPACING_X) + ext_x_c;

  assign blocked_r_c = $signed(edge_r_c + EDGE_W'(STEP_X)) > $signed(EDGE_W'(BOUND_R));
  assign blocked_l_c = $signed(edge_l_c - EDGE_W'(STEP_X)) < $signed(EDGE_W'(BOUND_L));
  assign blocked_c   = (direction_q == DIR_LEFT) ? blocked_l_c : blocked_r_c;

  // Bottom edge as it would be after a drop taken this cycle.
  assign bottom_next_c = EDGE_W'(START_Y + ALIEN_H + STEP_Y)
                       + EDGE_W'(int'(row_b_c) * ALIEN_SPACING_Y)
                       + EDGE_W'(offset_y_q);
  assign invade_c      = bottom_next_c >= EDGE_W'(INVADE_Y);

  assign active_c = (state_q == MARCH) || (state_q == DESCEND);

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    offset_x_d   = offset_x_q;
    offset_y_d   = offset_y_q;
    direction_d  = direction_q;
    step_pulse_d = 1'b0;
    descending_d = 1'b0;
    cleared_d    = cleared_q;
    invaded_d    = invaded_q;

    if (restart) begin
      state_d     = IDLE;
      frame_cnt_d = '0;
      offset_x_d  = '0;
      offset_y_d  = '0;
      direction_d = DIR_RIGHT;
      cleared_d   = 1'b0;
      invaded_d   = 1'b0;
    end else if (((state_q == IDLE) || active_c) && !any_alive_c) begin
      state_d   = CLEARED;
      cleared_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) state_d = MARCH;
        end
        MARCH, DESCEND: begin
          if (enable) begin
            state_d = blocked_c ? DESCEND : MARCH;
            if (frame_tick) begin
              if (step_due_c) begin
                frame_cnt_d  = '0;
                step_pulse_d = 1'b1;
                if (blocked_c) begin
                  descending_d = 1'b1;
                  offset_y_d   = offset_y_q + OFFSET_W'(STEP_Y);
                  direction_d  = ~direction_q;
                  state_d      = MARCH;
                  if (invade_c) begin
                    state_d   = INVADED;
                    invaded_d = 1'b1;
                  end
                end else if (direction_q == DIR_RIGHT) begin
                  offset_x_d = offset_x_q + OFFSET_W'(STEP_X);
                end else begin
                  offset_x_d = offset_x_q - OFFSET_W'(STEP_X);
                end
              end else begin
                frame_cnt_d = frame_cnt_q + PER_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      offset_x_q   <= '0;
      offset_y_q   <= '0;
      direction_q  <= DIR_RIGHT;
      step_pulse_q <= 1'b0;
      descending_q <= 1'b0;
      cleared_q    <= 1'b0;
      invaded_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      offset_x_q   <= offset_x_d;
      offset_y_q   <= offset_y_d;
      direction_q  <= direction_d;
      step_pulse_q <= step_pulse_d;
      descending_q <= descending_d;
      cleared_q    <= cleared_d;
      invaded_q    <= invaded_d;
    end
  end

  assign offset_x   = offset_x_q;
  assign offset_y   = offset_y_q;
  assign step_pulse = step_pulse_q;
  assign direction  = direction_q;
  assign descending = descending_q;
  assign cleared    = cleared_q;
  assign invaded    = invaded_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_formation_march_controller.sv
// Bench for formation_march_controller: vector table, directed march sequences
// and randomized traffic against an arithmetic reference model.
module tb_formation_march_controller;

  localparam int NR = 3;
  localparam int NC = 5;
  localparam int NB = NR * NC;
  localparam int TICK_LIMIT = 2000;

  logic clk = 1'b0;
  logic rst, frame_tick, enable, restart;
  logic [NB-1:0] alive;
  logic signed [15:0] offset_x;
  logic [15:0] offset_y;
  logic step_pulse, direction, descending, cleared, invaded;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 marching, 3 cleared, 4 invaded.
  int m_ph, m_ox, m_oy, m_dir, m_cnt, m_pulse, m_desc, m_clr, m_inv;
  int l_ox, l_oy, l_dir, l_desc;

  always #5 clk = ~clk;

  formation_march_controller dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .restart      (restart),
    .alive_matrix (alive),
    .offset_x     (offset_x),
    .offset_y     (offset_y),
    .step_pulse   (step_pulse),
    .direction    (direction),
    .descending   (descending),
    .cleared      (cleared),
    .invaded      (invaded),
    .state_o      (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void extents(input logic [NB-1:0] a, output int n,
                                  output int cl, output int cr, output int rb);
    n = 0; cl = NC; cr = -1; rb = -1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (a[r*NC + c]) begin
          n++;
          if (c < cl) cl = c;
          if (c > cr) cr = c;
          if (r > rb) rb = r;
        end
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_ox = 0; m_oy = 0; m_dir = 0; m_cnt = 0;
    m_pulse = 0; m_desc = 0; m_clr = 0; m_inv = 0;
  endfunction

  function automatic void model_edge();
    int n, cl, cr, rb, per, edge_px;
    extents(alive, n, cl, cr, rb);
    m_pulse = 0;
    m_desc  = 0;
    if (rst || restart) model_reset();
    else if ((m_ph == 0 || m_ph == 1) && n == 0) begin
      m_ph = 3; m_clr = 1;
    end else if (m_ph == 0) begin
      if (enable) m_ph = 1;
    end else if (m_ph == 1 && enable && frame_tick) begin
      per = 2 + (n - 1) * 2;
      if (m_cnt + 1 >= per) begin
        m_cnt = 0;
        m_pulse = 1;
        if (m_dir == 0) begin
          edge_px = 100 + cr * 64 + 32 + m_ox;
          if (edge_px + 8 > 640) m_desc = 1; else m_ox += 8;
        end else begin
          edge_px = 100 + cl * 64 + m_ox;
          if (edge_px - 8 < 0) m_desc = 1; else m_ox -= 8;
        end
        if (m_desc) begin
          m_oy += 16;
          m_dir = 1 - m_dir;
          if (50 + rb * 32 + 16 + m_oy >= 400) begin m_ph = 4; m_inv = 1; end
        end
      end else m_cnt++;
    end
  endfunction

  task automatic compare_all();
    int st;
    st = (state_o == 3'd2) ? 1 : int'(state_o);
    chk("step_pulse", int'(step_pulse), m_pulse);
    chk("offset_x",   int'(offset_x),   m_ox);
    chk("offset_y",   int'(offset_y),   m_oy);
    chk("direction",  int'(direction),  m_dir);
    chk("descending", int'(descending), m_desc);
    chk("cleared",    int'(cleared),    m_clr);
    chk("invaded",    int'(invaded),    m_inv);
    chk("state",      st,               m_ph);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic hard_reset();
    frame_tick = 0; restart = 0;
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    compare_all();
    cycle();
    rst = 0;
  endtask

  task automatic tick(output bit pulsed);
    frame_tick = 1;
    cycle();
    pulsed = step_pulse;
    if (step_pulse) begin
      l_ox = int'(offset_x); l_oy = int'(offset_y);
      l_dir = int'(direction); l_desc = int'(descending);
    end
    frame_tick = 0;
    cycle();
  endtask

  task automatic run_steps(input int n, output int ticks);
    int steps;
    bit p;
    steps = 0; ticks = 0;
    while (steps < n && ticks < TICK_LIMIT) begin
      tick(p);
      ticks++;
      if (p) steps++;
    end
    if (steps < n) chk("step_timeout", steps, n);
  endtask

  typedef struct {
    logic          tk;
    logic          en;
    logic          rs;
    logic [NB-1:0] al;
    int            pulse;
    int            ox;
    int            st;
    int            clr;
  } vec_t;

  function automatic vec_t mk(input logic tk, input logic en, input logic rs,
                              input logic [NB-1:0] al, input int pulse,
                              input int ox, input int st, input int clr);
    vec_t v;
    v.tk = tk; v.en = en; v.rs = rs; v.al = al;
    v.pulse = pulse; v.ox = ox; v.st = st; v.clr = clr;
    return v;
  endfunction

  initial begin
    vec_t vecs[14];
    bit p;
    int t, npulse, ndesc;
    logic [NB-1:0] one;

    rst = 0; frame_tick = 0; enable = 0; restart = 0; alive = '1;
    l_ox = 0; l_oy = 0; l_dir = 0; l_desc = 0;
    one = NB'(1);

    // Single alien at (0,0): period 2, far from both bounds.
    vecs[0]  = mk(0, 0, 0, one,          0, 0,  0, 0);
    vecs[1]  = mk(0, 1, 0, one,          0, 0,  1, 0);
    vecs[2]  = mk(1, 1, 0, one,          0, 0,  1, 0);
    vecs[3]  = mk(1, 1, 0, one,          1, 8,  1, 0);
    vecs[4]  = mk(0, 1, 0, one,          0, 8,  1, 0);
    vecs[5]  = mk(1, 0, 0, one,          0, 8,  1, 0);
    vecs[6]  = mk(1, 1, 0, one,          0, 8,  1, 0);
    vecs[7]  = mk(1, 1, 0, one,          1, 16, 1, 0);
    vecs[8]  = mk(0, 1, 1, one,          0, 0,  0, 0);
    vecs[9]  = mk(0, 1, 0, '0,           0, 0,  3, 1);
    vecs[10] = mk(1, 1, 0, one,          0, 0,  3, 1);
    vecs[11] = mk(0, 0, 1, one,          0, 0,  0, 0);
    vecs[12] = mk(1, 1, 0, NB'(3),       0, 0,  1, 0);
    vecs[13] = mk(1, 1, 0, NB'(3),       0, 0,  1, 0);

    hard_reset();
    chk("reset_state", int'(state_o), 0);

    for (int i = 0; i < 14; i++) begin
      frame_tick = vecs[i].tk; enable = vecs[i].en;
      restart = vecs[i].rs;    alive = vecs[i].al;
      cycle();
      chk($sformatf("vec%0d_pulse", i), int'(step_pulse), vecs[i].pulse);
      chk($sformatf("vec%0d_ox", i),    int'(offset_x),   vecs[i].ox);
      chk($sformatf("vec%0d_state", i), int'(state_o),    vecs[i].st);
      chk($sformatf("vec%0d_clr", i),   int'(cleared),    vecs[i].clr);
    end
    frame_tick = 0; restart = 0;

    // Full formation: first step after the 30th tick.
    hard_reset();
    alive = '1; enable = 1;
    cycle();
    npulse = 0;
    for (int i = 1; i < 30; i++) begin
      tick(p);
      if (p) npulse++;
    end
    chk("early_pulses", npulse, 0);
    tick(p);
    chk("first_step_pulse", int'(p), 1);
    chk("first_step_ox", l_ox, 8);
    chk("first_step_dir", l_dir, 0);

    run_steps(30, t);
    chk("right_end_ox", l_ox, 248);
    chk("right_end_desc", l_desc, 0);
    run_steps(1, t);
    chk("drop1_desc", l_desc, 1);
    chk("drop1_oy", l_oy, 16);
    chk("drop1_dir", l_dir, 1);
    chk("drop1_ox", l_ox, 248);

    run_steps(43, t);
    chk("left_end_ox", l_ox, -96);
    run_steps(1, t);
    chk("drop2_desc", l_desc, 1);
    chk("drop2_oy", l_oy, 32);
    chk("drop2_dir", l_dir, 0);

    // Kill column 4: period 24, right bound moves out by one pitch.
    for (int r = 0; r < NR; r++) alive[r*NC + 4] = 1'b0;
    run_steps(1, t);
    chk("kill_period_ticks", t, 24);
    chk("kill_first_ox", l_ox, -88);
    run_steps(50, t);
    chk("kill_right_ox", l_ox, 312);
    chk("kill_right_desc", l_desc, 0);
    run_steps(1, t);
    chk("kill_drop_desc", l_desc, 1);
    chk("kill_drop_ox", l_ox, 312);

    // Mid-period kill shrinks the period under an advanced counter.
    hard_reset();
    alive = '1; enable = 1;
    cycle();
    for (int i = 0; i < 20; i++) tick(p);
    alive = NB'(15'h03FF);
    tick(p);
    chk("midkill_pulse", int'(p), 1);

    // Bottom row only: march until invasion.
    hard_reset();
    alive = NB'(15'h7C00); enable = 1;
    cycle();
    ndesc = 0;
    for (int i = 0; i < 1000 && !invaded; i++) begin
      run_steps(1, t);
      if (t >= TICK_LIMIT) break;
      if (l_desc != 0) ndesc++;
    end
    chk("inv_descents", ndesc, 17);
    chk("inv_oy", int'(offset_y), 272);
    chk("inv_flag", int'(invaded), 1);
    chk("inv_state", int'(state_o), 4);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick(p);
      if (p) npulse++;
    end
    chk("inv_no_steps", npulse, 0);

    // Clear on the tick that would have stepped.
    hard_reset();
    alive = '1; enable = 1;
    cycle();
    for (int i = 0; i < 29; i++) tick(p);
    alive = '0; frame_tick = 1;
    cycle();
    frame_tick = 0;
    chk("clr_no_pulse", int'(step_pulse), 0);
    chk("clr_flag", int'(cleared), 1);
    chk("clr_state", int'(state_o), 3);

    restart = 1; alive = '1;
    cycle();
    restart = 0;
    chk("restart_ox", int'(offset_x), 0);
    chk("restart_state", int'(state_o), 0);
    chk("restart_clr", int'(cleared), 0);

    // Asynchronous reset while marching.
    cycle();
    for (int i = 0; i < 30; i++) tick(p);
    chk("pre_rst_ox", int'(offset_x), 8);
    hard_reset();
    chk("rst_ox", int'(offset_x), 0);
    chk("rst_state", int'(state_o), 0);

    // Randomized traffic against the model.
    alive = '1;
    for (int i = 0; i < 4000; i++) begin
      frame_tick = ($urandom_range(1, 0) == 1);
      enable     = ($urandom_range(15, 0) != 0);
      restart    = ($urandom_range(299, 0) == 0);
      if (restart) alive = '1;
      else if ($urandom_range(59, 0) == 0) alive[$urandom_range(NB-1, 0)] = 1'b0;
      cycle();
    end
    frame_tick = 0; restart = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
